serial_mult_ctrl: RTL and testbench



---
 rtl/serial_mult_pkg.sv | 34 +++
 rtl/serial_mult_datapath.sv | 54 +++++
 rtl/serial_mult_ctrl.sv | 134 +++++++++++++
 tb/tb_serial_mult_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_mult_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_mult_pkg
// Description : Shared definitions for the bit-serial shift-add multiplier:
//               sequencer state encoding and a constant clog2 helper used to
//               size the step counter.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package serial_mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  // Bits needed to hold values 0..value-1.
  function automatic int clog2(input int value);
    int result;
    int remain;
    result = 0;
    remain = value - 1;
    for (int i = 0; i < 32; i++) begin
      if (remain > 0) begin
        result = result + 1;
        remain = remain >> 1;
      end
    end
    return result;
  endfunction

endpackage : serial_mult_pkg
`default_nettype wire

// File: rtl/serial_mult_datapath.sv
`default_nettype none
// ============================================================================
// Module      : serial_mult_datapath
// Description : Operand/accumulator registers of the shift-add multiplier.
//               i_load captures the operands and clears the accumulator;
//               i_shift performs one add-and-shift-right step.
// Ports       : CLK, RST (async, active low)
//               i_load, i_shift   - control from the sequencer
//               i_a, i_b          - multiplicand / multiplier
//               o_prod_next       - {acc,mq} as they will be after the
//                                   current step (used to capture the result)
// Revision    : 1.0 - initial release
// ============================================================================
module serial_mult_datapath #(
  parameter int WIDTH = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               i_load,
  input  logic               i_shift,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic [2*WIDTH-1:0] o_prod_next
);

  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mq;
  logic [WIDTH-1:0] w_addend;
  logic [WIDTH:0]   w_sum;

  // One extra bit on the sum keeps the carry; it becomes the new acc MSB.
  assign w_addend    = r_mq[0] ? r_mcand : '0;
  assign w_sum       = {1'b0, r_acc} + {1'b0, w_addend};
  // The sum LSB drops into the top of mq as the multiplier shifts out.
  assign o_prod_next = {w_sum[WIDTH:1], w_sum[0], r_mq[WIDTH-1:1]};

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_mcand <= '0;
      r_acc   <= '0;
      r_mq    <= '0;
    end else if (i_load) begin
      r_mcand <= i_a;
      r_acc   <= '0;
      r_mq    <= i_b;
    end else if (i_shift) begin
      r_acc   <= w_sum[WIDTH:1];
      r_mq    <= {w_sum[0], r_mq[WIDTH-1:1]};
    end
  end

endmodule : serial_mult_datapath
`default_nettype wire

// File: rtl/serial_mult_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_mult_ctrl
// Description : Sequencer for the bit-serial shift-add multiplier. Accepts
//               operands on START/READY, runs WIDTH shift steps, and holds
//               the 2*WIDTH-bit product on DONE until ACK.
// Ports       : CLK, RST (async, active low)
//               START, A, B   - request and operands (sampled on accept)
//               ACK           - consumer acknowledge of DONE
//               READY/BUSY/DONE - registered state flags (IDLE/RUN/FINISH)
//               LOAD          - pulse in the first RUN cycle
//               SHIFT_EN      - high on each RUN cycle performing a step
//               PRODUCT       - result, valid while DONE
//               COUNT         - completed shift steps
// Revision    : 1.0 - initial release
// ============================================================================
module serial_mult_ctrl
  import serial_mult_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int CW    = clog2(WIDTH + 1)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic               ACK,
  output logic               READY,
  output logic               BUSY,
  output logic               DONE,
  output logic               LOAD,
  output logic               SHIFT_EN,
  output logic [2*WIDTH-1:0] PRODUCT,
  output logic [CW-1:0]      COUNT
);

  localparam logic [CW-1:0] c_last_step = CW'(WIDTH - 1);
  localparam logic [CW-1:0] c_one       = CW'(1);

  state_t               r_state;
  state_t               w_next_state;
  logic                 w_accept;
  logic                 w_last_step;
  logic                 r_ready;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_load;
  logic                 r_shift_en;
  logic [2*WIDTH-1:0]   r_product;
  logic [CW-1:0]        r_count;
  logic [2*WIDTH-1:0]   w_prod_next;

  // The datapath loads on the accept edge and steps on every edge that
  // closes a cycle with SHIFT_EN high, so the registered flag drives it.
  serial_mult_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .CLK         (CLK),
    .RST         (RST),
    .i_load      (w_accept),
    .i_shift     (r_shift_en),
    .i_a         (A),
    .i_b         (B),
    .o_prod_next (w_prod_next)
  );

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_last_step  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (START) begin
          w_accept     = 1'b1;
          w_next_state = ST_RUN;
        end
      end
      ST_RUN: begin
        // The step taken on this edge is the last one; capture its result.
        if (r_count == c_last_step) begin
          w_last_step  = 1'b1;
          w_next_state = ST_FINISH;
        end
      end
      ST_FINISH: begin
        if (ACK) begin
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state    <= ST_IDLE;
      r_ready    <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_load     <= 1'b0;
      r_shift_en <= 1'b0;
      r_product  <= '0;
      r_count    <= '0;
    end else begin
      r_state    <= w_next_state;
      r_ready    <= (w_next_state == ST_IDLE);
      r_busy     <= (w_next_state == ST_RUN);
      r_done     <= (w_next_state == ST_FINISH);
      r_load     <= w_accept;
      r_shift_en <= (w_next_state == ST_RUN);
      if (w_accept) begin
        r_count <= '0;
      end else if (r_state == ST_RUN) begin
        r_count <= r_count + c_one;
      end
      if (w_last_step) begin
        r_product <= w_prod_next;
      end
    end
  end

  assign READY    = r_ready;
  assign BUSY     = r_busy;
  assign DONE     = r_done;
  assign LOAD     = r_load;
  assign SHIFT_EN = r_shift_en;
  assign PRODUCT  = r_product;
  assign COUNT    = r_count;

endmodule : serial_mult_ctrl
`default_nettype wire

// File: tb/tb_serial_mult_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_mult_ctrl
// Description : Self-checking bench for serial_mult_ctrl (WIDTH=4). Accepted
//               requests push A*B onto a scoreboard; each DONE pops it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_mult_ctrl;

  localparam int W  = 4;
  localparam int CW = 3;

  logic          CLK;
  logic          RST;
  logic          START;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic          ACK;
  logic          READY;
  logic          BUSY;
  logic          DONE;
  logic          LOAD;
  logic          SHIFT_EN;
  logic [2*W-1:0] PRODUCT;
  logic [CW-1:0] COUNT;

  int tests = 0;
  int fails = 0;
  logic [2*W-1:0] sb[$];
  logic [2*W-1:0] exp_p;

  serial_mult_ctrl #(.WIDTH(W)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .START    (START),
    .A        (A),
    .B        (B),
    .ACK      (ACK),
    .READY    (READY),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .LOAD     (LOAD),
    .SHIFT_EN (SHIFT_EN),
    .PRODUCT  (PRODUCT),
    .COUNT    (COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Scoreboard producer: an accepted request expects A*B; reset discards all.
  always @(posedge CLK or negedge RST) begin
    if (!RST) sb.delete();
    else if (START && READY) sb.push_back({4'b0, A} * {4'b0, B});
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    RST = 1'b1;
    #1 RST = 1'b0;
    #2;
    tests++; if (READY !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", READY); end
    tests++; if ({BUSY, DONE, LOAD, SHIFT_EN} !== 4'b0000) begin fails++; $display("FAIL reset_flags: got %b want 0000", {BUSY, DONE, LOAD, SHIFT_EN}); end
    tests++; if (PRODUCT !== 8'd0) begin fails++; $display("FAIL reset_product: got %0d want 0", PRODUCT); end
    tests++; if (COUNT !== 3'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", COUNT); end
    #3 RST = 1'b1;
    tick;
    tests++; if ({READY, BUSY} !== 2'b10) begin fails++; $display("FAIL reset_idle: got READY,BUSY=%b want 10", {READY, BUSY}); end
  endtask

  task automatic test_basic;
    int n, busy_c, shift_c, load_c;
    A = 4'd13; B = 4'd11; START = 1'b1;
    tick;
    START = 1'b0;
    tests++; if ({READY, BUSY, LOAD} !== 3'b011) begin fails++; $display("FAIL basic_accept: got READY,BUSY,LOAD=%b want 011", {READY, BUSY, LOAD}); end
    n = 1; busy_c = int'(BUSY); shift_c = int'(SHIFT_EN); load_c = int'(LOAD);
    while (!DONE && n < 20) begin
      tick; n++;
      busy_c += int'(BUSY); shift_c += int'(SHIFT_EN); load_c += int'(LOAD);
    end
    tests++; if (n !== 5) begin fails++; $display("FAIL basic_latency: got %0d edges want 5", n); end
    tests++; if (busy_c !== 4) begin fails++; $display("FAIL basic_busy: got %0d cycles want 4", busy_c); end
    tests++; if (shift_c !== 4 || load_c !== 1) begin fails++; $display("FAIL basic_ctl: got shift=%0d load=%0d want 4/1", shift_c, load_c); end
    tests++; if (PRODUCT !== 8'h8F) begin fails++; $display("FAIL basic_product: got %0h want 8f", PRODUCT); end
    tests++;
    if (sb.size() == 0) begin fails++; $display("FAIL basic_sb: got empty scoreboard want entry"); end
    else begin exp_p = sb.pop_front(); if (PRODUCT !== exp_p) begin fails++; $display("FAIL basic_sb: got %0d want %0d", PRODUCT, exp_p); end end
    repeat (2) tick;
    tests++; if ({DONE, READY} !== 2'b10 || PRODUCT !== 8'h8F) begin fails++; $display("FAIL basic_hold: got DONE,READY=%b PRODUCT=%0h want 10/8f", {DONE, READY}, PRODUCT); end
    ACK = 1'b1;
    tick;
    ACK = 1'b0;
    tests++; if ({DONE, READY} !== 2'b01) begin fails++; $display("FAIL basic_ack: got DONE,READY=%b want 01", {DONE, READY}); end
  endtask

  task automatic test_corners;
    int ca[4] = '{15, 0, 1, 15};
    int cb[4] = '{15, 9, 15, 0};
    int cp[4] = '{225, 0, 15, 0};
    int n;
    for (int i = 0; i < 4; i++) begin
      A = 4'(ca[i]); B = 4'(cb[i]); START = 1'b1;
      tick;
      START = 1'b0;
      n = 1;
      while (!DONE && n < 20) begin tick; n++; end
      tests++; if (n !== 5) begin fails++; $display("FAIL corner_latency[%0d]: got %0d edges want 5", i, n); end
      tests++; if (PRODUCT !== 8'(cp[i])) begin fails++; $display("FAIL corner_product[%0d]: got %0d want %0d", i, PRODUCT, cp[i]); end
      tests++;
      if (sb.size() == 0) begin fails++; $display("FAIL corner_sb[%0d]: got empty scoreboard want entry", i); end
      else begin exp_p = sb.pop_front(); if (PRODUCT !== exp_p) begin fails++; $display("FAIL corner_sb[%0d]: got %0d want %0d", i, PRODUCT, exp_p); end end
      ACK = 1'b1;
      tick;
      ACK = 1'b0;
      tick;
    end
  endtask

  task automatic test_ignore_start;
    int n;
    A = 4'd5; B = 4'd12; START = 1'b1;
    tick;
    tick;
    A = 4'd3; B = 4'd3;
    n = 2;
    while (!DONE && n < 20) begin tick; n++; end
    tests++; if (n !== 5) begin fails++; $display("FAIL ignore_latency: got %0d edges want 5", n); end
    tests++; if (PRODUCT !== 8'd60 || COUNT !== 3'd4) begin fails++; $display("FAIL ignore_product: got %0d count %0d want 60/4", PRODUCT, COUNT); end
    tests++;
    if (sb.size() == 0) begin fails++; $display("FAIL ignore_sb: got empty scoreboard want entry"); end
    else begin exp_p = sb.pop_front(); if (PRODUCT !== exp_p) begin fails++; $display("FAIL ignore_sb: got %0d want %0d", PRODUCT, exp_p); end end
    repeat (2) tick;
    tests++; if ({DONE, READY, BUSY} !== 3'b100) begin fails++; $display("FAIL ignore_finish: got DONE,READY,BUSY=%b want 100", {DONE, READY, BUSY}); end
    ACK = 1'b1;
    tick;
    START = 1'b0; ACK = 1'b0;
    tests++; if ({DONE, READY, BUSY, LOAD} !== 4'b0100) begin fails++; $display("FAIL ignore_ackstart: got DONE,READY,BUSY,LOAD=%b want 0100", {DONE, READY, BUSY, LOAD}); end
    tick;
    tests++; if ({READY, BUSY} !== 2'b10) begin fails++; $display("FAIL ignore_idle: got READY,BUSY=%b want 10", {READY, BUSY}); end
  endtask

  task automatic test_reset_mid;
    int n;
    logic saw_done;
    A = 4'd9; B = 4'd9; START = 1'b1;
    tick;
    START = 1'b0;
    tick;
    tick;
    #2 RST = 1'b0;
    #1;
    tests++; if ({READY, BUSY, DONE, LOAD, SHIFT_EN} !== 5'b10000) begin fails++; $display("FAIL midrst_flags: got %b want 10000", {READY, BUSY, DONE, LOAD, SHIFT_EN}); end
    tests++; if (PRODUCT !== 8'd0 || COUNT !== 3'd0) begin fails++; $display("FAIL midrst_regs: got product %0d count %0d want 0/0", PRODUCT, COUNT); end
    #2 RST = 1'b1;
    saw_done = 1'b0;
    repeat (8) begin tick; saw_done = saw_done | DONE; end
    tests++; if (saw_done !== 1'b0) begin fails++; $display("FAIL midrst_nodone: got DONE seen=%b want 0", saw_done); end
    A = 4'd6; B = 4'd7; START = 1'b1;
    tick;
    START = 1'b0;
    n = 1;
    while (!DONE && n < 20) begin tick; n++; end
    tests++; if (PRODUCT !== 8'd42) begin fails++; $display("FAIL midrst_product: got %0d want 42", PRODUCT); end
    tests++;
    if (sb.size() == 0) begin fails++; $display("FAIL midrst_sb: got empty scoreboard want entry"); end
    else begin exp_p = sb.pop_front(); if (PRODUCT !== exp_p) begin fails++; $display("FAIL midrst_sb: got %0d want %0d (stale entry kept)", PRODUCT, exp_p); end end
    ACK = 1'b1;
    tick;
    ACK = 1'b0;
  endtask

  task automatic test_back_to_back;
    int rises, ready_c, load_c, shift_c;
    rises = 0; ready_c = 0; load_c = 0; shift_c = 0;
    A = 4'd5; B = 4'd5; START = 1'b1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      tick;
      load_c  += int'(LOAD);
      shift_c += int'(SHIFT_EN);
      if (rises == 1 && READY) ready_c++;
      if (ACK) begin
        ACK = 1'b0;
        if (rises == 2) break;
      end else if (DONE) begin
        rises++;
        tests++; if (PRODUCT !== ((rises == 1) ? 8'd25 : 8'd27)) begin fails++; $display("FAIL b2b_product[%0d]: got %0d want %0d", rises, PRODUCT, (rises == 1) ? 25 : 27); end
        tests++;
        if (sb.size() == 0) begin fails++; $display("FAIL b2b_sb[%0d]: got empty scoreboard want entry", rises); end
        else begin exp_p = sb.pop_front(); if (PRODUCT !== exp_p) begin fails++; $display("FAIL b2b_sb[%0d]: got %0d want %0d", rises, PRODUCT, exp_p); end end
        ACK = 1'b1;
        if (rises == 1) begin A = 4'd9; B = 4'd3; end
        else START = 1'b0;
      end
    end
    START = 1'b0; ACK = 1'b0;
    tests++; if (rises !== 2) begin fails++; $display("FAIL b2b_ops: got %0d results want 2", rises); end
    tests++; if (ready_c !== 1) begin fails++; $display("FAIL b2b_ready_gap: got %0d cycles want 1", ready_c); end
    tests++; if (load_c !== 2 || shift_c !== 8) begin fails++; $display("FAIL b2b_ctl: got load=%0d shift=%0d want 2/8", load_c, shift_c); end
    tick;
  endtask

  task automatic test_sweep;
    int n;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        A = 4'(a); B = 4'(b); START = 1'b1;
        tick;
        START = 1'b0;
        n = 1;
        while (!DONE && n < 20) begin tick; n++; end
        tests++;
        if (DONE !== 1'b1) begin fails++; $display("FAIL sweep_timeout %0d*%0d: got no DONE want DONE", a, b); end
        else if (sb.size() == 0) begin fails++; $display("FAIL sweep_sb %0d*%0d: got empty scoreboard want entry", a, b); end
        else begin
          exp_p = sb.pop_front();
          if (PRODUCT !== exp_p || COUNT !== 3'd4) begin
            fails++; $display("FAIL sweep %0d*%0d: got %0d count %0d want %0d count 4", a, b, PRODUCT, COUNT, exp_p);
          end
        end
        ACK = 1'b1;
        tick;
        ACK = 1'b0;
      end
    end
  endtask

  initial begin
    START = 1'b0; A = '0; B = '0; ACK = 1'b0;
    test_reset;
    test_basic;
    test_corners;
    test_ignore_start;
    test_reset_mid;
    test_back_to_back;
    test_sweep;
    tests++; if (sb.size() !== 0) begin fails++; $display("FAIL sb_leftover: got %0d entries want 0", sb.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_serial_mult_ctrl
`default_nettype wire
